// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt pending/enable logic with per-line level or edge capture.
// Define SARATOGA_IRQ_SYNC_EN to place a SYNC_STAGES-deep synchronizer on ext_irq.
module irq_ctrl #(
  parameter int                 NUM_EXT     = 16,
  parameter logic [NUM_EXT-1:0] EDGE_MASK   = '0,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               timer_irq,
  input  logic               sw_irq,
  input  logic [31:0]        mie,
  input  logic               mstatus_mie,
  input  logic               trap_insert,
  input  logic [31:0]        trap_cause,
  input  logic               trap_is_mret,
  input  logic               mip_clr_we,
  input  logic [31:0]        mip_clr_mask,
  output logic [31:0]        mip,
  output logic [31:0]        interrupts
);

  logic [NUM_EXT-1:0] ext_sync;
  logic [NUM_EXT-1:0] ext_prev;
  logic [NUM_EXT-1:0] ext_armed;
  logic               samp_vld;
  logic [31:0]        mip_d;
  logic               ack_int;
  logic               unused_in;

`ifdef SARATOGA_IRQ_SYNC_EN
  logic [NUM_EXT-1:0]     sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;

  // vld_q tracks which synchronizer stages hold real samples rather than reset zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      vld_q <= '0;
    end else begin
      sync_q[0] <= ext_irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ext_sync = sync_q[SYNC_STAGES-1];
  assign samp_vld = vld_q[SYNC_STAGES-1];
  assign unused_in = ^{trap_cause, mip_clr_mask};
`else
  assign ext_sync  = ext_irq;
  assign samp_vld  = 1'b1;
  assign unused_in = ^{trap_cause, mip_clr_mask, (SYNC_STAGES != 0)};
`endif

  assign ack_int = trap_insert & trap_cause[31] & ~trap_is_mret;

  // An edge line only captures after a genuine low sample since reset (armed),
  // so a line already high when reset drops does not fake an edge.
  always_comb begin
    logic edge_clr;
    edge_clr = 1'b0;
    mip_d    = '0;
    mip_d[3] = sw_irq;
    mip_d[7] = timer_irq;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (EDGE_MASK[i]) begin
        edge_clr = (mip_clr_we & mip_clr_mask[16+i]) |
                   (ack_int & (trap_cause[4:0] == 5'(16 + i)));
        mip_d[16+i] = (ext_sync[i] & ~ext_prev[i] & ext_armed[i]) |
                      (mip[16+i] & ~edge_clr);
      end else begin
        mip_d[16+i] = ext_sync[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mip       <= '0;
      ext_prev  <= '0;
      ext_armed <= '0;
    end else begin
      mip       <= mip_d;
      ext_prev  <= ext_sync;
      ext_armed <= ext_armed | ({NUM_EXT{samp_vld}} & ~ext_sync);
    end
  end

  assign interrupts = mstatus_mie ? (mip & mie) : '0;

endmodule
